// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline-side request/response signals and the memory-side
// request/response signals handled by mem_access_unit.
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr;
  logic                  MemRead;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  // Pipeline plus memory environment that drives requests and responses
  modport master (
    output addr, MemRead, MemWrite, wdata, mem_rdata, mem_ready,
    input  stall, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  // The access unit itself
  modport slave (
    input  addr, MemRead, MemWrite, wdata, mem_rdata, mem_ready,
    output stall, rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access unit: IDLE -> WAIT -> DONE handshake with a bus-error timeout.
// Optional MEM_MISALIGN_TRAP_EN: misaligned requests trap instead of being word-aligned.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK  = DATA_WIDTH'(3);

  state_t                state_reg, state_next;
  logic [7:0]            count_reg, count_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  we_reg, we_next;
  logic [DATA_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  stall_comb;
  logic                  one_req;
  logic                  misalign_trap;
  logic [7:0]            count_inc;

  assign one_req   = bus.MemRead ^ bus.MemWrite;
  assign count_inc = count_reg + 8'd1;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_trap = |(bus.addr & ALIGN_MASK);
`else
  assign misalign_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    rdata_next = rdata_reg;
    err_next   = 1'b0;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    stall_comb = 1'b0;

    case (state_reg)
      IDLE: begin
        stall_comb = bus.MemRead | bus.MemWrite;
        if (bus.MemRead && bus.MemWrite) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else if (one_req && misalign_trap) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else if (one_req) begin
          // Without the trap, the low address bits are simply dropped
          addr_next  = bus.addr & ~ALIGN_MASK;
          wdata_next = bus.wdata;
          we_next    = bus.MemWrite;
          count_next = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        stall_comb = 1'b1;
        if (bus.mem_ready) begin
          if (!we_reg) begin
            rdata_next = bus.mem_rdata;
          end
          state_next = DONE;
        end else begin
          count_next = count_inc;
          if (count_inc == TIMEOUT_CNT) begin
            rdata_next = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end

      // Requests still visible here belong to the retiring instruction
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.stall     = stall_comb;
  assign bus.rdata     = rdata_reg;
  assign bus.err       = err_reg;
  assign bus.mem_req   = (state_reg == WAIT);
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized traffic,
// expected results computed per transaction from the access rules.
module tb_mem_access_unit;

  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  typedef struct {
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            stalls;
    int            reqs;
    logic          err;
    logic [DW-1:0] rdata;
    bit            chk_rdata;
  } exp_t;

  logic clk;
  logic rst;

  mem_access_unit_if #(.DATA_WIDTH(DW)) bus ();

  mem_access_unit #(
    .DATA_WIDTH(DW),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            mon_off = 1'b1;
  logic [DW-1:0] rdata_model = '0;
  bit            rdata_known = 1'b1;
  int            txn_id = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access, push its expected outcome, and play the memory side
  task automatic do_txn(input bit rd, input bit wr, input logic [DW-1:0] a,
                        input logic [DW-1:0] wd, input int delay, input logic [DW-1:0] rd_val);
    exp_t e;
    bit   trap;
    int   waits;
    trap = rd && wr;
`ifdef MEM_MISALIGN_TRAP_EN
    if (rd != wr && a[1:0] != 2'b00) trap = 1'b1;
`endif
    e.addr  = {a[DW-1:2], 2'b00};
    e.we    = wr;
    e.wdata = wd;
    if (trap) begin
      e.stalls    = 1;
      e.reqs      = 0;
      e.err       = 1'b1;
      rdata_known = 1'b0;
    end else begin
      waits    = (delay < TIMEOUT) ? delay : TIMEOUT;
      e.stalls = 1 + waits;
      e.reqs   = waits;
      if (delay <= TIMEOUT) begin
        e.err = 1'b0;
        if (rd) begin
          rdata_model = rd_val;
          rdata_known = 1'b1;
        end
      end else begin
        e.err       = 1'b1;
        rdata_model = '0;
        rdata_known = 1'b1;
      end
    end
    e.rdata     = rdata_model;
    e.chk_rdata = rdata_known;
    sb_q.push_back(e);
    $display("[TB] txn %0d rd=%0b wr=%0b addr=%h wdata=%h delay=%0d", txn_id, rd, wr, a, wd, delay);
    txn_id++;

    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    if (!trap) begin
      for (int k = 1; k <= TIMEOUT; k++) begin
        bus.mem_ready = (k == delay);
        bus.mem_rdata = (k == delay) ? rd_val : $urandom;
        @(posedge clk); #1;
        if (k == delay) break;
      end
    end
    // DONE cycle: request still held and stray ready must both be ignored
    bus.mem_ready = 1'($urandom);
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.mem_ready = 1'($urandom);
  endtask

  // Monitor: per-cycle memory-side checks and per-transaction completion checks
  initial begin : monitor
    int   stall_cnt;
    int   req_cnt;
    exp_t e;
    stall_cnt = 0;
    req_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst || mon_off) begin
        stall_cnt = 0;
        req_cnt   = 0;
      end else begin
        if (bus.mem_req) begin
          req_cnt++;
          if (!bus.stall) chk("mem_req_without_stall", 32'(bus.stall), 32'd1);
          if (sb_q.size() == 0) begin
            chk("unexpected_mem_req", 32'(bus.mem_req), 32'd0);
          end else begin
            chk("mem_addr", bus.mem_addr, sb_q[0].addr);
            chk("mem_we", 32'(bus.mem_we), 32'(sb_q[0].we));
            if (sb_q[0].we) chk("mem_wdata", bus.mem_wdata, sb_q[0].wdata);
          end
        end
        if (bus.stall) begin
          stall_cnt++;
          if (bus.err) chk("err_while_stalled", 32'(bus.err), 32'd0);
        end else if (stall_cnt > 0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(stall_cnt), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
            chk("mem_req_cycles", 32'(req_cnt), 32'(e.reqs));
            chk("err", 32'(bus.err), 32'(e.err));
            if (e.chk_rdata) chk("rdata", bus.rdata, e.rdata);
          end
          stall_cnt = 0;
          req_cnt   = 0;
        end else if (bus.err) begin
          chk("err_outside_done", 32'(bus.err), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit            rd;
    bit            wr;
    int            op;
    logic [DW-1:0] a;
    rst           = 1'b1;
    bus.addr      = '0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.wdata     = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", bus.rdata, '0);
    chk("reset_err", 32'(bus.err), 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, '0);
    chk("reset_mem_wdata", bus.mem_wdata, '0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_off = 1'b0;

    // Directed cases
    do_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 1, 32'hDEAD_BEEF);
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 3, 32'h0BAD_0BAD);
    do_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, TIMEOUT + 3, 32'h5555_AAAA);
    do_txn(1'b1, 1'b1, 32'h0000_3000, 32'hFFFF_0000, 1, 32'h1111_1111);
    do_txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, 2, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b0, 32'h0000_4000, 32'h0, TIMEOUT, 32'h0F0F_0F0F);

    // Reset asserted in the second WAIT cycle abandons the access silently
    @(posedge clk); #1;
    mon_off      = 1'b1;
    bus.MemRead  = 1'b1;
    bus.addr     = 32'h0000_5000;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst         = 1'b1;
    bus.MemRead = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_stall", 32'(bus.stall), 32'd0);
    chk("abort_err", 32'(bus.err), 32'd0);
    chk("abort_rdata", bus.rdata, '0);
    @(posedge clk); #1;
    chk("abort_err_after", 32'(bus.err), 32'd0);
    rst         = 1'b0;
    rdata_model = '0;
    rdata_known = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_mem_req", 32'(bus.mem_req), 32'd0);
    mon_off = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      rd = (op <= 3) || (op == 7);
      wr = (op >= 4);
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_txn(rd, wr, a, $urandom, int'($urandom_range(1, TIMEOUT + 2)), $urandom);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        bus.mem_ready = 1'($urandom);
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data and address width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum WAIT cycles before a bus error; legal range 1..255.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 addr  input  DATA_WIDTH  effective address from the sign-extend/address stage.
REQ-007 MemRead  input  1  load request.
REQ-008 MemWrite  input  1  store request.
REQ-009 wdata  input  DATA_WIDTH  store data.
REQ-010 stall  output  1  holds the pipeline while an access is pending.
REQ-011 rdata  output  DATA_WIDTH  registered load data.
REQ-012 err  output  1  one-cycle pulse flagging a failed access.
REQ-013 mem_req / mem_we  output  1 each  memory request strobe and write enable.
REQ-014 mem_addr / mem_wdata  output  DATA_WIDTH each  latched address and store data.
REQ-015 mem_rdata  input  DATA_WIDTH; mem_ready  input  1  memory response and completion.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-017 IDLE, exactly one of MemRead/MemWrite high: latch addr, wdata and mem_we=MemWrite; clear the timeout counter; go to WAIT next edge.
REQ-018 IDLE, MemRead and MemWrite both high: no access; err=1 and go to DONE next edge.
REQ-019 stall SHALL be combinational: 1 in IDLE when MemRead or MemWrite is high, 1 in WAIT, 0 in DONE and in idle IDLE.
REQ-020 mem_req SHALL be 1 only in WAIT; mem_addr, mem_wdata and mem_we SHALL remain stable for the whole of WAIT.
REQ-021 WAIT with mem_ready=1: register mem_rdata into rdata on a load (rdata unchanged on a store); go to DONE.
REQ-022 WAIT with mem_ready=0: increment the counter; on the edge where the counter reaches TIMEOUT, set rdata=0, err=1 and go to DONE.
REQ-023 mem_ready outside WAIT SHALL be ignored.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE; MemRead/MemWrite in DONE SHALL be ignored, because they belong to the retiring instruction.
REQ-025 err SHALL be high only during DONE cycles entered through an error path.
REQ-026 Minimum latency: request seen in cycle 0, mem_req in cycle 1, mem_ready in cycle 1 -> DONE in cycle 2, giving 2 stall cycles.
REQ-027 rdata SHALL hold its last value until the next completed load, error or reset.

Reset
REQ-028 rst SHALL force IDLE at any time, including mid-WAIT, and abandon the access without err.
REQ-029 Reset values SHALL be: rdata=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.

Configuration
REQ-030 With MEM_MISALIGN_TRAP_EN defined, an IDLE request with addr[1:0]!=0 SHALL skip WAIT, issue no mem_req, and go to DONE with err=1 (1 stall cycle).
REQ-031 Without MEM_MISALIGN_TRAP_EN, mem_addr[1:0] SHALL be forced to 0 and the access SHALL proceed normally.

Verification
REQ-032 Load, addr=0x00001004, mem_ready in the first WAIT cycle with mem_rdata=0xDEADBEEF -> stall high for 2 cycles, rdata=0xDEADBEEF in DONE, err=0.
REQ-033 Store, addr=0x00000010, wdata=0x12345678, mem_ready after 3 WAIT cycles -> mem_we=1, mem_wdata=0x12345678, stall high for 4 cycles, rdata unchanged.
REQ-034 Load with mem_ready held low, TIMEOUT=4 -> DONE after 4 WAIT cycles, err pulse of 1 cycle, rdata=0.
REQ-035 MemRead=MemWrite=1 -> no mem_req, err=1 in the following cycle.
REQ-036 rst pulsed in the second WAIT cycle -> state IDLE, mem_req=0 immediately, err stays 0.
REQ-037 Load at addr=0x00000006 -> with MEM_MISALIGN_TRAP_EN: err=1 and no mem_req; without it: mem_addr=0x00000004.
